cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Sequencing controller that refills one cache block on a miss. It issues eight pipelined word reads to main memory and steers the returning words into the data array. It then writes the 9-bit metadata entry ({valid, tag}) into the register-based tag array. It sits between the cache hit/miss logic and the memory port in the MEM and IF stages of the 5-stage pipeline.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- Parameters:
  - WORDS_PER_BLOCK, 8: words per cache block; must be a power of two.
  - ADDR_W, 16: byte address width.
  - TAG_W, 8: tag width; the metadata entry is TAG_W+1 = 9 bits.
- Ports:
  - clk  in  1  pipeline clock
  - rst  in  1  synchronous active-high reset
  - miss_detected  in  1  level, held by the requester until fsm_busy falls
  - miss_address  in  ADDR_W  byte address of the missing access
  - memory_data_valid  in  1  a returned word is present this cycle
  - memory_data  in  16  returned word
  - fsm_busy  out  1  a fill is in progress; the requester stalls
  - memory_read  out  1  read request this cycle
  - memory_address  out  ADDR_W  request address
  - write_data_array  out  1  write enable for the data array
  - data_word_offset  out  3  word index for the data-array write
  - data_out  out  16  word to write (pass-through of memory_data)
  - write_tag_array  out  1  write enable for the metadata register
  - meta_out  out  TAG_W+1  {1'b1, tag} written into the metadata register

## Operation
- States: IDLE, FILL, TAGWR.
- IDLE:
  - On miss_detected, latch block_base = miss_address with bits [3:0] cleared, and latch tag = miss_address[15:8].
  - Clear req_cnt and rcv_cnt, then go to FILL.
- FILL, request side:
  - While req_cnt < 8: memory_read = 1 and memory_address = block_base + 2*req_cnt; increment req_cnt every cycle.
  - When req_cnt == 8: memory_read = 0.
- FILL, receive side:
  - On memory_data_valid: write_data_array = 1, data_word_offset = rcv_cnt, data_out = memory_data, and rcv_cnt increments.
  - Data returns in order. Request and receive may overlap in the same cycle.
  - When memory_data_valid arrives with rcv_cnt == 7, go to TAGWR.
- TAGWR (one cycle):
  - write_tag_array = 1 and meta_out = {1'b1, tag}.
  - Go to IDLE.
- fsm_busy = 1 in FILL and TAGWR.
- memory_data_valid in IDLE or TAGWR is ignored; no write occurs.
- miss_detected while busy is ignored; no re-latch occurs.
- Counter widths: req_cnt is 4 bits and saturates at 8; rcv_cnt is 3 bits. There is no wrap-around within a fill.
- Reset mid-fill:
  - Go to IDLE immediately and clear both counters.
  - No tag write occurs, so the metadata stays invalid. Partially written data-array words are don't-care.
- Reset values: fsm_busy, memory_read, write_data_array and write_tag_array are 0. memory_address, data_word_offset and meta_out are 0. data_out follows memory_data.

## Timing
- miss_detected is sampled in IDLE at cycle 0. FILL starts at cycle 1.
- Requests go out on cycles 1–8, offsets 0x0–0xE.
- With a 4-cycle memory, data is valid on cycles 5–12 and the data-array writes happen on those same cycles.
- write_tag_array pulses on cycle 13, and fsm_busy falls at cycle 14.
- Overall fill latency is 13 busy cycles plus the memory latency beyond 4.
- write_data_array and data_out are combinational from memory_data_valid and memory_data in FILL. All other outputs are registered or derived from state.
- The earliest back-to-back miss is sampled at cycle 14.

## Configuration
- Macro: CACHE_FILL_PERF_CNT_EN.
- Defined:
  - Adds output miss_count [15:0], which increments on every IDLE→FILL transition and wraps at 0xFFFF→0.
  - Reset value is 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cache_pkg:
  - Constants WORDS_PER_BLOCK, BLOCK_OFFSET_W = 4, TAG_W = 8, META_W = 9.
  - Typedef fill_state_t covering IDLE, FILL and TAGWR.
  - Function meta_pack(tag) returning {1'b1, tag}.
- One sub-module: fill_counter, a parameterised up-counter with clear and saturation. It is instantiated for req_cnt and for rcv_cnt.

## Test plan
- Clean fill:
  - Stimulus: miss_address 0x3A56, 4-cycle memory.
  - Response: requests 0x3A50–0x3A5E on cycles 1–8, offsets 0–7 written on cycles 5–12, meta_out 0x13A on cycle 13, busy low on cycle 14.
- Stalled returns:
  - Stimulus: memory_data_valid gapped (one valid every 3 cycles).
  - Response: exactly 8 data writes with offsets in order, then the tag write one cycle after the 8th word.
- Spurious inputs:
  - Stimulus: memory_data_valid in IDLE, and miss_detected toggled mid-fill.
  - Response: no writes in IDLE, and the latched address and tag stay unchanged.
- Reset mid-fill:
  - Stimulus: rst asserted at cycle 7.
  - Response: next cycle fsm_busy = 0 and memory_read = 0, and write_tag_array never pulses.
- Back-to-back misses:
  - Stimulus: 0x0010 then 0xFFF0, with miss_detected held.
  - Response: the second fill starts at cycle 14 and its meta_out is 0x1FF.
- Performance counter:
  - Stimulus: CACHE_FILL_PERF_CNT_EN defined, 3 fills.
  - Response: miss_count = 3. Preload 0xFFFF, run 1 fill, expect 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block refill controller.
// Used by cache_fill_fsm and fill_counter.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int TAG_W           = 8;
  localparam int META_W          = TAG_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TAGWR = 2'd2
  } fill_state_t;

  function automatic logic [META_W-1:0] meta_pack(
    input logic [TAG_W-1:0] tag
  );
    return {1'b1, tag};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Up-counter with synchronous clear that saturates at MAX.
// Instantiated for the request and receive word counters.
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != W'(MAX)))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block refill sequencer: pipelined word reads, data steering, tag write.
// Optional miss counter output enabled by CACHE_FILL_PERF_CNT_EN.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int TAG_W           = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               fsm_busy,
  output logic                               memory_read,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
  output logic [15:0]                        data_out,
  output logic                               write_tag_array,
  output logic [TAG_W:0]                     meta_out
`ifdef CACHE_FILL_PERF_CNT_EN
  ,
  output logic [15:0]                        miss_count
`endif
);

  import cache_pkg::*;

  localparam int RCV_W = $clog2(WORDS_PER_BLOCK);
  localparam int REQ_W = RCV_W + 1;
  localparam int OFF_W = RCV_W + 1;

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [REQ_W-1:0]  req_cnt;
  logic [RCV_W-1:0]  rcv_cnt;
  logic              req_clr, req_inc;
  logic              rcv_clr, rcv_inc;
  logic              unused_addr;

  assign unused_addr = ^miss_address[OFF_W-1:0];

  fill_counter #(.W(REQ_W), .MAX(WORDS_PER_BLOCK)) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (req_clr),
    .inc_i (req_inc),
    .cnt_o (req_cnt)
  );

  fill_counter #(.W(RCV_W), .MAX(WORDS_PER_BLOCK-1)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (rcv_clr),
    .inc_i (rcv_inc),
    .cnt_o (rcv_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
    end
  end

  assign data_out = memory_data;

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    tag_d            = tag_q;
    req_clr          = 1'b0;
    req_inc          = 1'b0;
    rcv_clr          = 1'b0;
    rcv_inc          = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_offset = '0;
    write_tag_array  = 1'b0;
    meta_out         = '0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          tag_d   = miss_address[ADDR_W-1 -: TAG_W];
          req_clr = 1'b1;
          rcv_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt < REQ_W'(WORDS_PER_BLOCK)) begin
          memory_read    = 1'b1;
          memory_address = base_q +
            {{(ADDR_W-REQ_W-1){1'b0}}, req_cnt, 1'b0};
          req_inc        = 1'b1;
        end
        // Returns are in order, so the receive count is the word index.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_offset = rcv_cnt;
          rcv_inc          = 1'b1;
          if (rcv_cnt == RCV_W'(WORDS_PER_BLOCK-1))
            state_d = TAGWR;
        end
      end
      TAGWR: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        meta_out        = meta_pack(tag_q);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      miss_cnt_q <= '0;
    else if ((state_q == IDLE) && miss_detected)
      miss_cnt_q <= miss_cnt_q + 16'd1;
  end

  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a queue-based memory model.
// Miss counter checks are active when CACHE_FILL_PERF_CNT_EN is defined.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_word_offset;
  logic [15:0] data_out;
  logic        write_tag_array;
  logic [8:0]  meta_out;
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] miss_count;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          rdy;
    logic [15:0] data;
  } word_t;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_offset  (data_word_offset),
    .data_out          (data_out),
    .write_tag_array   (write_tag_array),
    .meta_out          (meta_out)
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    .miss_count        (miss_count)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Starts and finishes at a negedge; the DUT must be idle on entry.
  // mode 0: word returned as soon as ready, 1: only every 3rd cycle,
  // 2: random gaps. tcyc reports the cycle of the tag write.
  task automatic run_fill(input logic [15:0] addr, input int lat,
                          input int mode, input bit toggle,
                          output int tcyc);
    word_t       q[$];
    word_t       w;
    logic [15:0] base;
    logic [8:0]  meta;
    int          nw;
    bit          done;
    bit          take;
    base = addr & 16'hFFF0;
    meta = {1'b1, addr[15:8]};
    nw   = 0;
    done = 0;
    tcyc = 1000;
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (c <= 8) begin
        w.rdy  = c + lat;
        w.data = 16'($urandom);
        q.push_back(w);
      end
      take = 0;
      if (q.size() > 0 && q[0].rdy <= c) begin
        case (mode)
          0:       take = 1;
          1:       take = (c % 3 == 0);
          default: take = ($urandom_range(1) == 1);
        endcase
      end
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
      if (take) begin
        memory_data_valid = 1'b1;
        memory_data       = q[0].data;
      end else if (c == tcyc) begin
        memory_data_valid = 1'b1;
      end
      if (toggle && c >= 2 && c <= 6) begin
        miss_detected = 1'($urandom);
        miss_address  = 16'($urandom);
      end else if (toggle && c == 7) begin
        miss_detected = 1'b1;
        miss_address  = addr;
      end
      @(negedge clk);
      total++;
      if (fsm_busy !== (c <= tcyc)) begin
        $display("FAIL busy c=%0d got %b want %b", c, fsm_busy, c <= tcyc);
      end else passed++;
      total++;
      if (memory_read !== (c <= 8)) begin
        $display("FAIL read c=%0d got %b want %b", c, memory_read, c <= 8);
      end else passed++;
      if (c <= 8) begin
        total++;
        if (memory_address !== base + 16'(2 * (c - 1))) begin
          $display("FAIL req_addr c=%0d got %h want %h", c,
                   memory_address, base + 16'(2 * (c - 1)));
        end else passed++;
      end
      total++;
      if (write_data_array !== take) begin
        $display("FAIL data_wr c=%0d got %b want %b", c,
                 write_data_array, take);
      end else passed++;
      if (take) begin
        total++;
        if (data_word_offset !== 3'(nw) || data_out !== q[0].data) begin
          $display("FAIL word c=%0d got off %0d data %h want off %0d data %h",
                   c, data_word_offset, data_out, nw, q[0].data);
        end else passed++;
      end
      total++;
      if (write_tag_array !== (c == tcyc)) begin
        $display("FAIL tag_wr c=%0d got %b want %b", c,
                 write_tag_array, c == tcyc);
      end else passed++;
      if (c == tcyc) begin
        total++;
        if (meta_out !== meta) begin
          $display("FAIL meta c=%0d got %h want %h", c, meta_out, meta);
        end else passed++;
      end
      if (take) begin
        void'(q.pop_front());
        nw++;
        if (nw == 8) tcyc = c + 1;
      end
      if (c == tcyc + 1) done = 1;
    end
    total++;
    if (!done) begin
      $display("FAIL fill_timeout got %0d words want 8", nw);
    end else passed++;
    memory_data_valid = 1'b0;
    miss_detected     = 1'b0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    memory_data_valid = 1'b1;
    memory_data       = 16'hC3E1;
    miss_detected     = 1'b1;
    miss_address      = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0) begin
      $display("FAIL reset_ctl got %b want 0000",
               {fsm_busy, memory_read, write_data_array, write_tag_array});
    end else passed++;
    total++;
    if (memory_address !== 16'h0 || data_word_offset !== 3'h0 ||
        meta_out !== 9'h0) begin
      $display("FAIL reset_vals got %h %h %h want 0 0 0",
               memory_address, data_word_offset, meta_out);
    end else passed++;
    total++;
    if (data_out !== 16'hC3E1) begin
      $display("FAIL reset_data_out got %h want c3e1", data_out);
    end else passed++;
    do_reset();
  endtask

  task automatic test_clean_fill();
    int t;
    run_fill(16'h3A56, 4, 0, 0, t);
    total++;
    if (t !== 13) begin
      $display("FAIL clean_tag_cycle got %0d want 13", t);
    end else passed++;
  endtask

  task automatic test_stalled();
    int t;
    run_fill(16'h5C3F, 4, 1, 0, t);
    total++;
    if (t < 14) begin
      $display("FAIL stalled_tag_cycle got %0d want >=14", t);
    end else passed++;
  endtask

  task automatic test_spurious();
    int t;
    miss_detected = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      @(negedge clk);
      total++;
      if ({fsm_busy, write_data_array, write_tag_array, memory_read} !== 4'b0) begin
        $display("FAIL idle_valid i=%0d got %b want 0000", i,
                 {fsm_busy, write_data_array, write_tag_array, memory_read});
      end else passed++;
    end
    memory_data_valid = 1'b0;
    run_fill(16'hB7E2, 3, 2, 1, t);
  endtask

  task automatic test_reset_mid_fill();
    miss_detected = 1'b1;
    miss_address  = 16'h4440;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      memory_data_valid = (c >= 5);
      memory_data       = 16'($urandom);
      if (c == 7) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    miss_detected = 1'b0;
    @(negedge clk);
    total++;
    if (fsm_busy !== 1'b0 || memory_read !== 1'b0) begin
      $display("FAIL rst_mid got busy %b read %b want 0 0",
               fsm_busy, memory_read);
    end else passed++;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      memory_data_valid = 1'($urandom);
      @(negedge clk);
      total++;
      if (write_tag_array !== 1'b0 || write_data_array !== 1'b0) begin
        $display("FAIL rst_after i=%0d got tag %b data %b want 0 0", i,
                 write_tag_array, write_data_array);
      end else passed++;
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t;
    run_fill(16'h0010, 4, 0, 0, t);
    run_fill(16'hFFF0, 4, 0, 0, t);
    total++;
    if (t !== 13) begin
      $display("FAIL b2b_tag_cycle got %0d want 13", t);
    end else passed++;
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 6; i++)
      run_fill(16'($urandom), $urandom_range(6, 1), $urandom_range(2),
               1'($urandom), t);
  endtask

`ifdef CACHE_FILL_PERF_CNT_EN
  task automatic test_perf();
    int t;
    do_reset();
    total++;
    if (miss_count !== 16'd0) begin
      $display("FAIL perf_reset got %0d want 0", miss_count);
    end else passed++;
    for (int i = 0; i < 3; i++)
      run_fill(16'($urandom), 4, 0, 0, t);
    total++;
    if (miss_count !== 16'd3) begin
      $display("FAIL perf_count got %0d want 3", miss_count);
    end else passed++;
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_clean_fill();
    test_stalled();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
`ifdef CACHE_FILL_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
